pipeline_hazard_ctrl: RTL and testbench
=======================================

Name: pipeline_hazard_ctrl

Overview:
Central sequencer for the 5-stage pipeline. It drives enable and flush controls for the four pipeline registers (IF/ID, ID/EX, EX/MEM, MEM/WB) and the PC. It resolves instruction-memory wait, data-memory wait, load-use hazards, taken-branch/jump flushes and halt. It also keeps a saturating stall-cycle counter for performance debug.

Parameters:
CNT_W, 16, width of stall_count.
NUM_FLUSH_ON_BR, 2, number of younger stages flushed on a taken branch resolved in EX: IF/ID and ID/EX. Legal values are 2 or 3; 3 also flushes EX/MEM.

Ports:
CLK  input  1  system clock
nRST  input  1  reset, asynchronous, active-low
ihit  input  1  instruction memory returned data this cycle
dhit  input  1  data memory completed access this cycle
dREN_EX_MEM  input  1  load in MEM stage
dWEN_EX_MEM  input  1  store in MEM stage
dREN_ID_EX  input  1  load in EX stage
Rt_ID_EX  input  5  load destination in EX stage
Rs_IF_ID  input  5  source rs of instruction in ID
Rt_IF_ID  input  5  source rt of instruction in ID
branch_taken  input  1  EX resolved taken branch or jump (PC redirect)
halt_MEM_WB  input  1  halt instruction reached WB
pc_en  output  1  PC register load enable
if_id_en, id_ex_en, ex_mem_en, mem_wb_en  output  1 each  register advance enables
if_id_flush, id_ex_flush, ex_mem_flush  output  1 each  load bubble (all-zero) on next edge; flush overrides enable
iREN  output  1  instruction fetch request
halted  output  1  core halted
stall_count  output  CNT_W  cycles with pc_en=0 outside HALT, saturating

Behaviour:
- State machine: RUN, DWAIT, HALT. Reset state is RUN.
- Reset values: all enables 0, all flushes 0, iREN 0, halted 0, stall_count 0. While nRST is low, the outputs are forced to these values.
- Combinational outputs are evaluated in priority order. Default: all enables 1, flushes 0, iREN 1.
- P1, HALT state: all enables 0, flushes 0, iREN 0, halted 1. HALT is absorbing until reset.
- P2, halt_MEM_WB=1 in RUN: mem_wb_en 1; all others 0. Next state is HALT, so halted rises the next cycle.
- P3, data wait: mem_req = dREN_EX_MEM|dWEN_EX_MEM.
  - mem_req & !dhit: all enables 0, pc_en 0, iREN 0. This freezes the pipeline so the memory request stays stable. Next state is DWAIT.
  - In DWAIT with dhit: default outputs apply, then P4–P6. Next state is RUN.
  - mem_req & dhit in RUN: no stall.
- P4, branch_taken: pc_en 1 (redirect), if_id_flush 1, id_ex_flush 1. ex_mem_flush is 1 only if NUM_FLUSH_ON_BR=3. Branch beats load-use, because the dependent instruction is discarded.
- P5, load-use: luh = dREN_ID_EX & (Rt_ID_EX!=0) & (Rt_ID_EX==Rs_IF_ID | Rt_ID_EX==Rt_IF_ID).
  - Response: pc_en 0, if_id_en 0, id_ex_flush 1. EX/MEM and MEM/WB advance.
  - Exactly one bubble is inserted, because the load leaves EX on the next edge.
- P6, ihit=0 (RUN, no higher event): pc_en 0, if_id_flush 1. Later stages advance.
  - Combined with P5: pc_en 0, if_id_en 0, if_id_flush 0 (hold the ID instruction), id_ex_flush 1.
- stall_count increments on each rising edge where state!=HALT, pc_en=0 and nRST=1. It holds at 2^CNT_W-1.
- Reset asserted mid-DWAIT: immediate return to RUN with reset outputs. A pending memory request is abandoned.
- Simultaneous events:
  - halt + mem wait: halt wins, because halt is in WB and MEM holds nothing older.
  - branch + ihit=0: flush wins, and pc_en=1 loads the target.

Decomposition:
- cpu_types_pkg gets typedef enum logic [1:0] hzd_state_t {RUN, DWAIT, HALT} and localparam ZERO_REG = 5'd0.
- The regbits_t type from cpu_types_pkg is used for register IDs.
- Ports are bundled in a new interface, pipeline_hazard_ctrl_if.vh.
- One natural sub-module: sat_counter (parameterised width, enable, async reset) for stall_count.

Test Plan:
- Reset: nRST=0 for 2 cycles with random inputs -> all enables 0, flushes 0, stall_count 0. Release with ihit=1 and no hazards -> all enables 1 on the first cycle.
- Load-use: dREN_ID_EX=1, Rt_ID_EX=5, Rs_IF_ID=5, ihit=1 -> pc_en 0, if_id_en 0, id_ex_flush 1 for exactly 1 cycle; stall_count 0→1. Repeat with Rt_ID_EX=0 -> no stall.
- Dmem wait: dREN_EX_MEM=1, dhit=0 for 3 cycles, then dhit=1 -> all enables 0 for 3 cycles, state DWAIT, enables 1 on the dhit cycle, stall_count=3.
- Branch over load-use: branch_taken=1 together with luh=1 -> pc_en 1, if_id_flush 1, id_ex_flush 1, if_id_en 1.
- Halt: halt_MEM_WB=1 -> mem_wb_en 1 and other enables 0 that cycle; next cycle halted 1, iREN 0. Stays halted 10 cycles regardless of inputs; stall_count unchanged.
- Saturation (CNT_W=4): ihit=0 for 20 cycles -> stall_count stops at 15, if_id_flush 1 each cycle.

Source files
------------

// File: rtl/cpu_types_pkg.sv
// Shared CPU types: register IDs and the hazard sequencer state encoding.
package cpu_types_pkg;
  typedef logic [4:0] regbits_t;

  typedef enum logic [1:0] {
    RUN   = 2'd0,
    DWAIT = 2'd1,
    HALT  = 2'd2
  } hzd_state_t;

  localparam regbits_t ZERO_REG = 5'd0;
endpackage

// File: rtl/pipeline_hazard_ctrl_sat_counter.sv
// Saturating up-counter with enable; holds at all-ones.
module sat_counter #(
  parameter int W = 16
) (
  input  logic         CLK,
  input  logic         nRST,
  input  logic         en_i,
  output logic [W-1:0] count_o
);
  logic [W-1:0] count_q, count_d;

  // next count: step when enabled, stick at the top value
  always_comb begin
    count_d = count_q;
    if (en_i && (count_q != {W{1'b1}})) count_d = count_q + 1'b1;
  end

  // count register, cleared asynchronously
  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) count_q <= '0;
    else       count_q <= count_d;
  end

  assign count_o = count_q;
endmodule

// File: rtl/pipeline_hazard_ctrl.sv
// Pipeline sequencer: enables/flushes for the four pipeline registers and PC,
// resolving halt, data-memory wait, branch redirect, load-use and ifetch wait.
module pipeline_hazard_ctrl
  import cpu_types_pkg::*;
#(
  parameter int CNT_W           = 16,
  parameter int NUM_FLUSH_ON_BR = 2
) (
  input  logic             CLK,
  input  logic             nRST,
  input  logic             ihit,
  input  logic             dhit,
  input  logic             dREN_EX_MEM,
  input  logic             dWEN_EX_MEM,
  input  logic             dREN_ID_EX,
  input  regbits_t         Rt_ID_EX,
  input  regbits_t         Rs_IF_ID,
  input  regbits_t         Rt_IF_ID,
  input  logic             branch_taken,
  input  logic             halt_MEM_WB,
  output logic             pc_en,
  output logic             if_id_en,
  output logic             id_ex_en,
  output logic             ex_mem_en,
  output logic             mem_wb_en,
  output logic             if_id_flush,
  output logic             id_ex_flush,
  output logic             ex_mem_flush,
  output logic             iREN,
  output logic             halted,
  output logic [CNT_W-1:0] stall_count
);
  hzd_state_t state_q, state_d;
  logic       mem_req, luh;

  assign mem_req = dREN_EX_MEM | dWEN_EX_MEM;
  assign luh     = dREN_ID_EX && (Rt_ID_EX != ZERO_REG) &&
                   ((Rt_ID_EX == Rs_IF_ID) || (Rt_ID_EX == Rt_IF_ID));

  // priority resolution of controls and next state
  always_comb begin
    pc_en        = 1'b1;
    if_id_en     = 1'b1;
    id_ex_en     = 1'b1;
    ex_mem_en    = 1'b1;
    mem_wb_en    = 1'b1;
    if_id_flush  = 1'b0;
    id_ex_flush  = 1'b0;
    ex_mem_flush = 1'b0;
    iREN         = 1'b1;
    state_d      = state_q;
    if (!nRST || state_q == HALT) begin
      // reset or halted: everything quiet
      {pc_en, if_id_en, id_ex_en, ex_mem_en, mem_wb_en, iREN} = '0;
    end else if (halt_MEM_WB) begin
      // retire the halt, freeze everything younger
      {pc_en, if_id_en, id_ex_en, ex_mem_en, iREN} = '0;
      state_d = HALT;
    end else if (mem_req && !dhit) begin
      // freeze so the outstanding memory request stays stable
      {pc_en, if_id_en, id_ex_en, ex_mem_en, mem_wb_en, iREN} = '0;
      state_d = DWAIT;
    end else begin
      state_d = RUN;
      if (branch_taken) begin
        // redirect wins: the dependent instruction is discarded anyway
        if_id_flush  = 1'b1;
        id_ex_flush  = 1'b1;
        ex_mem_flush = (NUM_FLUSH_ON_BR == 3);
      end else if (luh) begin
        // hold PC and ID, inject one bubble into EX; also covers ihit=0
        pc_en       = 1'b0;
        if_id_en    = 1'b0;
        id_ex_flush = 1'b1;
      end else if (!ihit) begin
        pc_en       = 1'b0;
        if_id_flush = 1'b1;
      end
    end
  end

  // state register; reset abandons any pending memory wait
  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) state_q <= RUN;
    else       state_q <= state_d;
  end

  assign halted = nRST && (state_q == HALT);

  sat_counter #(.W(CNT_W)) u_stall_cnt (
    .CLK     (CLK),
    .nRST    (nRST),
    .en_i    ((state_q != HALT) && !pc_en),
    .count_o (stall_count)
  );
endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// Directed bench for pipeline_hazard_ctrl with an expected-result queue.
module tb_pipeline_hazard_ctrl;
  import cpu_types_pkg::*;

  localparam int CNT_W = 4;

  logic CLK = 1'b0;
  logic nRST;
  logic ihit, dhit, dREN_EX_MEM, dWEN_EX_MEM, dREN_ID_EX, branch_taken, halt_MEM_WB;
  regbits_t Rt_ID_EX, Rs_IF_ID, Rt_IF_ID;
  logic pc_en, if_id_en, id_ex_en, ex_mem_en, mem_wb_en;
  logic if_id_flush, id_ex_flush, ex_mem_flush, iREN, halted;
  logic [CNT_W-1:0] stall_count;

  pipeline_hazard_ctrl #(.CNT_W(CNT_W), .NUM_FLUSH_ON_BR(2)) dut (
    .CLK(CLK), .nRST(nRST), .ihit(ihit), .dhit(dhit),
    .dREN_EX_MEM(dREN_EX_MEM), .dWEN_EX_MEM(dWEN_EX_MEM), .dREN_ID_EX(dREN_ID_EX),
    .Rt_ID_EX(Rt_ID_EX), .Rs_IF_ID(Rs_IF_ID), .Rt_IF_ID(Rt_IF_ID),
    .branch_taken(branch_taken), .halt_MEM_WB(halt_MEM_WB),
    .pc_en(pc_en), .if_id_en(if_id_en), .id_ex_en(id_ex_en), .ex_mem_en(ex_mem_en),
    .mem_wb_en(mem_wb_en), .if_id_flush(if_id_flush), .id_ex_flush(id_ex_flush),
    .ex_mem_flush(ex_mem_flush), .iREN(iREN), .halted(halted), .stall_count(stall_count)
  );

  always #5 CLK = ~CLK;

  // {pc, ifid, idex, exmem, memwb, fl_ifid, fl_idex, fl_exmem, iREN, halted}
  localparam logic [9:0] C_RST   = 10'b00000_000_0_0;
  localparam logic [9:0] C_DEF   = 10'b11111_000_1_0;
  localparam logic [9:0] C_FRZ   = 10'b00000_000_0_0;
  localparam logic [9:0] C_LUH   = 10'b00111_010_1_0;
  localparam logic [9:0] C_BR    = 10'b11111_110_1_0;
  localparam logic [9:0] C_NOIH  = 10'b01111_100_1_0;
  localparam logic [9:0] C_HALTW = 10'b00001_000_0_0;
  localparam logic [9:0] C_HLTD  = 10'b00000_000_0_1;

  typedef struct {
    logic [9:0] ctl;
    string      tag;
  } exp_t;

  exp_t             exp_q[$];
  int               errs = 0;
  int               checks = 0;
  logic [CNT_W-1:0] exp_cnt = '0;

  task automatic setin(input logic ih, input logic dh, input logic drm, input logic dwm,
                       input logic dre, input int rt, input int rs, input int rtif,
                       input logic br, input logic hl);
    ihit = ih; dhit = dh; dREN_EX_MEM = drm; dWEN_EX_MEM = dwm; dREN_ID_EX = dre;
    Rt_ID_EX = regbits_t'(rt); Rs_IF_ID = regbits_t'(rs); Rt_IF_ID = regbits_t'(rtif);
    branch_taken = br; halt_MEM_WB = hl;
  endtask

  task automatic rnd_in();
    setin(1'($urandom), 1'($urandom), 1'($urandom), 1'($urandom), 1'($urandom),
          int'($urandom_range(0, 31)), int'($urandom_range(0, 31)),
          int'($urandom_range(0, 31)), 1'($urandom), 1'($urandom));
  endtask

  // push expectation, compare on the falling edge, then advance past the rising edge
  task automatic cyc(input logic [9:0] ctl, input string tag);
    exp_t e;
    logic [9:0] obs;
    exp_q.push_back('{ctl, tag});
    @(negedge CLK);
    e = exp_q.pop_front();
    if (!nRST) exp_cnt = '0;
    obs = {pc_en, if_id_en, id_ex_en, ex_mem_en, mem_wb_en,
           if_id_flush, id_ex_flush, ex_mem_flush, iREN, halted};
    checks++;
    assert (obs === e.ctl) else begin
      errs++;
      $error("FAIL %s ctl got=%b want=%b", e.tag, obs, e.ctl);
    end
    checks++;
    assert (stall_count === exp_cnt) else begin
      errs++;
      $error("FAIL %s stall_count got=%0d want=%0d", e.tag, stall_count, exp_cnt);
    end
    if (nRST && !e.ctl[9] && !e.ctl[0] && exp_cnt != '1) exp_cnt = exp_cnt + 1'b1;
    @(posedge CLK);
    #1;
  endtask

  task automatic chk_state(input hzd_state_t want, input string tag);
    checks++;
    assert (dut.state_q === want) else begin
      errs++;
      $error("FAIL %s state got=%0d want=%0d", tag, dut.state_q, want);
    end
  endtask

  initial begin
    nRST = 1'b0;
    rnd_in();
    // reset with random inputs
    for (int i = 0; i < 2; i++) begin
      cyc(C_RST, "reset");
      rnd_in();
    end
    nRST = 1'b1;
    setin(1, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    cyc(C_DEF, "post_reset");

    // load-use on rs, one bubble, counter 0 -> 1
    setin(1, 0, 0, 0, 1, 5, 5, 0, 0, 0);
    cyc(C_LUH, "luh_rs");
    setin(1, 0, 0, 0, 0, 5, 5, 0, 0, 0);
    cyc(C_DEF, "luh_release");
    setin(1, 0, 0, 0, 1, 0, 0, 0, 0, 0);
    cyc(C_DEF, "luh_r0");
    setin(1, 0, 0, 0, 1, 7, 3, 7, 0, 0);
    cyc(C_LUH, "luh_rt");
    setin(1, 0, 0, 0, 1, 5, 6, 7, 0, 0);
    cyc(C_DEF, "luh_nomatch");

    // data-memory wait: 3 frozen cycles then completion
    for (int i = 0; i < 3; i++) begin
      setin(1, 0, 1, 0, 0, 0, 0, 0, 0, 0);
      cyc(C_FRZ, "dwait");
      chk_state(DWAIT, "dwait_state");
    end
    setin(1, 1, 1, 0, 0, 0, 0, 0, 0, 0);
    cyc(C_DEF, "dwait_hit");
    chk_state(RUN, "dwait_exit");
    setin(1, 1, 0, 1, 0, 0, 0, 0, 0, 0);
    cyc(C_DEF, "store_hit_run");

    // branch priority and ifetch wait combinations
    setin(1, 0, 0, 0, 1, 5, 5, 0, 1, 0);
    cyc(C_BR, "br_over_luh");
    setin(0, 0, 0, 0, 0, 0, 0, 0, 1, 0);
    cyc(C_BR, "br_over_noihit");
    setin(0, 0, 0, 0, 1, 9, 0, 9, 0, 0);
    cyc(C_LUH, "luh_noihit");
    setin(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    cyc(C_NOIH, "noihit");

    // reset in the middle of a data wait
    setin(1, 0, 1, 0, 0, 0, 0, 0, 0, 0);
    cyc(C_FRZ, "dwait_pre_rst");
    nRST = 1'b0;
    cyc(C_RST, "rst_in_dwait");
    chk_state(RUN, "rst_state");
    nRST = 1'b1;
    setin(1, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    cyc(C_DEF, "rst_dwait_release");

    // counter saturation at 15
    for (int i = 0; i < 20; i++) begin
      setin(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
      cyc(C_NOIH, "saturate");
    end

    // halt beats memory wait, then absorbing for 10 cycles
    nRST = 1'b0;
    cyc(C_RST, "reset2");
    nRST = 1'b1;
    setin(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    cyc(C_NOIH, "pre_halt");
    setin(1, 0, 1, 0, 0, 0, 0, 0, 0, 1);
    cyc(C_HALTW, "halt_wb");
    for (int i = 0; i < 10; i++) begin
      rnd_in();
      cyc(C_HLTD, "halted");
    end
    chk_state(HALT, "halt_state");

    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end
endmodule
